// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
//   Shared types and elaboration-time helpers for the BCD counter family.
//
//   Contents:
//     bcd_digit_t    : one packed BCD digit (4 bits)
//     bcd_word_t     : widest supported BCD word (BCD_MAX_DIGITS digits)
//     BCD_MAX_DIGIT  : largest legal digit value (9)
//     to_bcd()       : integer -> BCD word, used to build the MODULUS-1 constant
//     pow10()        : 10**n as a longint, used by the parameter range check
//     bcd_valid()    : load check (all digits <= 9 and value <= limit)
// ----------------------------------------------------------------------------
package bcd_pkg;

    localparam int BCD_MAX_DIGITS = 16;

    typedef logic [3:0]                  bcd_digit_t;
    typedef logic [4*BCD_MAX_DIGITS-1:0] bcd_word_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    // Convert a non-negative integer to packed BCD, digit 0 in [3:0].
    function automatic bcd_word_t to_bcd(int value, int digits);
        bcd_word_t r;
        int        v;
        r = '0;
        v = value;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[4*i +: 4] = bcd_digit_t'(v % 10);
                v           = v / 10;
            end
        end
        return r;
    endfunction

    function automatic longint pow10(int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Packed BCD words order exactly like their decimal values once every
    // digit is <= 9, so the range check is a plain unsigned compare.
    function automatic logic bcd_valid(bcd_word_t value, int digits, bcd_word_t limit);
        logic ok;
        ok = (value <= limit);
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if ((i < digits) && (value[4*i +: 4] > BCD_MAX_DIGIT)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// ----------------------------------------------------------------------------
// bcd_digit
//   Combinational single-digit BCD step cell. When cin is high the digit
//   steps once in the direction given by up; cout flags the wrap (9->0 when
//   counting up, 0->9 when counting down) so cells chain into a ripple of
//   carries/borrows. With cin low the digit passes through unchanged.
//
//   Ports:
//     d    : current digit value
//     up   : 1 = increment, 0 = decrement
//     cin  : carry-in (up) / borrow-in (down) -- step request for this digit
//     q    : stepped digit value
//     cout : carry-out (up) / borrow-out (down)
// ----------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    input  logic       up,
    input  logic       cin,
    output bcd_digit_t q,
    output logic       cout
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d == BCD_MAX_DIGIT) begin
                    q    = '0;
                    cout = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == '0) begin
                    q    = BCD_MAX_DIGIT;
                    cout = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// ----------------------------------------------------------------------------
// bcd_mod_counter
//   Cascadable up/down BCD counter with arbitrary modulus. Counts over
//   0..MODULUS-1 in packed BCD; COUT flags the cycle whose edge wraps the
//   count so it can drive EN of the next stage directly (same clock, no
//   ripple clocking).
//
//   Build option: define BCD_COUNTER_LOAD_EN to enable the synchronous
//   parallel load (with validity check). Without it LOAD and DIN are kept
//   on the port list but ignored, and COUT does not depend on LOAD.
//
//   Parameters:
//     DIGITS  : number of BCD digits (count width 4*DIGITS)
//     MODULUS : decimal modulus, 2 <= MODULUS <= 10**DIGITS
//
//   Ports:
//     CLK  : rising-edge clock
//     CLR  : synchronous active-high clear (highest priority)
//     EN   : count enable, one step per enabled cycle
//     UP   : 1 = count up, 0 = count down
//     LOAD : synchronous load strobe (overrides EN)
//     DIN  : BCD load value, digit 0 in [3:0]
//     DOUT : registered BCD count
//     COUT : combinational terminal-count carry/borrow
// ----------------------------------------------------------------------------
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                EN,
    input  logic                UP,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] DIN,
    output logic [4*DIGITS-1:0] DOUT,
    output logic                COUT
);

    localparam int           W        = 4 * DIGITS;
    localparam bcd_word_t    MAX_WORD = to_bcd(MODULUS - 1, DIGITS);
    localparam logic [W-1:0] MAX_BCD  = MAX_WORD[W-1:0];

    if ((DIGITS < 1) || (DIGITS > BCD_MAX_DIGITS) || (MODULUS < 2) ||
        (longint'(MODULUS) > pow10(DIGITS))) begin : g_bad_params
        $fatal(1, "bcd_mod_counter: DIGITS/MODULUS out of range");
    end

    // Plain BCD step of the whole word: digit 0 always steps, higher digits
    // step on the carry/borrow of the digit below.
    logic [W-1:0]    step_val;
    logic [DIGITS:0] chain;

    assign chain[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .d    (DOUT[4*g +: 4]),
            .up   (UP),
            .cin  (chain[g]),
            .q    (step_val[4*g +: 4]),
            .cout (chain[g+1])
        );
    end

    // The top-digit carry only matters when MODULUS == 10**DIGITS, and that
    // case is already covered by the modulus compare below.
    logic unused_chain;
    assign unused_chain = chain[DIGITS];

    logic at_terminal;
    assign at_terminal = UP ? (DOUT == MAX_BCD) : (DOUT == '0);

    logic [W-1:0] count_next;

    always_comb begin
        count_next = DOUT;
        if (EN) begin
            if (at_terminal) begin
                count_next = UP ? '0 : MAX_BCD;
            end else begin
                count_next = step_val;
            end
        end
    end

`ifdef BCD_COUNTER_LOAD_EN
    // Out-of-range or non-BCD load values clear the count so DOUT never
    // leaves 0..MODULUS-1.
    logic         load_ok;
    logic [W-1:0] load_val;

    assign load_ok  = bcd_valid(bcd_word_t'(DIN), DIGITS, MAX_WORD);
    assign load_val = load_ok ? DIN : '0;
    assign COUT     = EN & ~CLR & ~LOAD & at_terminal;
`else
    logic unused_load;
    assign unused_load = ^{LOAD, DIN};
    assign COUT        = EN & ~CLR & at_terminal;
`endif

    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        // NOTE: CLR is sampled on the clock edge (synchronous) and only the
        // count register needs clearing; there is no other state.
        if (CLR) begin
            DOUT <= '0;
        end
`ifdef BCD_COUNTER_LOAD_EN
        else if (LOAD) begin
            DOUT <= load_val;
        end
`endif
        else begin
            DOUT <= count_next;
        end
    end

endmodule
